// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default score geometry and the argmax FSM state encoding.
package cnn_pkg;

  localparam int BITWIDTH         = 8;
  localparam int FC1_OUTPUT_UNITS = 10;
  localparam int DEF_SCORE_WIDTH  = BITWIDTH * 2;
  localparam int DEF_NUM_CLASSES  = FC1_OUTPUT_UNITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/cnn_top2_update.sv
// Folds one candidate score into a running best/second-best pair.
// Strict signed compares, so an earlier (lower) index wins every tie.
module cnn_top2_update
  import cnn_pkg::*;
#(
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int IDX_WIDTH   = 4
) (
  input  logic [SCORE_WIDTH-1:0] cand_score,
  input  logic [IDX_WIDTH-1:0]   cand_idx,
  input  logic [SCORE_WIDTH-1:0] best_score,
  input  logic [IDX_WIDTH-1:0]   best_idx,
  input  logic [SCORE_WIDTH-1:0] second_score,
  input  logic [IDX_WIDTH-1:0]   second_idx,
  output logic [SCORE_WIDTH-1:0] new_best_score,
  output logic [IDX_WIDTH-1:0]   new_best_idx,
  output logic [SCORE_WIDTH-1:0] new_second_score,
  output logic [IDX_WIDTH-1:0]   new_second_idx
);

  always_comb begin
    new_best_score   = best_score;
    new_best_idx     = best_idx;
    new_second_score = second_score;
    new_second_idx   = second_idx;
    if ($signed(cand_score) > $signed(best_score)) begin
      new_best_score   = cand_score;
      new_best_idx     = cand_idx;
      new_second_score = best_score;
      new_second_idx   = best_idx;
    end else if ($signed(cand_score) > $signed(second_score)) begin
      new_second_score = cand_score;
      new_second_idx   = cand_idx;
    end
  end

endmodule

// File: rtl/cnn_argmax_top2.sv
// Post-classifier argmax: snapshots the score vector, scans one class per enabled
// cycle, and offers winner, runner-up and margin over a valid/ready handshake.
module cnn_argmax_top2
  import cnn_pkg::*;
#(
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clken,
  input  logic [SCORE_WIDTH*NUM_CLASSES-1:0] scores_in,
  input  logic                               scores_valid,
  output logic                               busy,
  output logic                               overrun,
  output logic [IDX_WIDTH-1:0]               class_idx,
  output logic [SCORE_WIDTH-1:0]             class_score,
  output logic [IDX_WIDTH-1:0]               runner_idx,
  output logic [SCORE_WIDTH:0]               margin,
  output logic                               result_valid,
  input  logic                               result_ready
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX       = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [IDX_WIDTH-1:0] FIRST_SCAN_IDX = IDX_WIDTH'(2);
  localparam bit                   TWO_CLASS      = (NUM_CLASSES == 2);

  argmax_state_t                      state;
  logic [SCORE_WIDTH*NUM_CLASSES-1:0] snapshot;
  logic [IDX_WIDTH-1:0]               k;
  logic [SCORE_WIDTH-1:0]             best_score, second_score;
  logic [IDX_WIDTH-1:0]               best_idx, second_idx;

  logic [SCORE_WIDTH-1:0] cand_score, cur_best_score, cur_second_score;
  logic [IDX_WIDTH-1:0]   cand_idx, cur_best_idx, cur_second_idx;
  logic [SCORE_WIDTH-1:0] upd_best_score, upd_second_score;
  logic [IDX_WIDTH-1:0]   upd_best_idx, upd_second_idx;
  logic [SCORE_WIDTH:0]   margin_next;
  logic                   handshake, capture, finish, overrun_next;

  assign busy         = (state != ST_IDLE);
  assign handshake    = (state == ST_DONE) && result_ready;
  assign capture      = clken && scores_valid && ((state == ST_IDLE) || handshake);
  assign finish       = capture ? TWO_CLASS : ((state == ST_SCAN) && clken && (k == LAST_IDX));
  assign overrun_next = clken && scores_valid && (state != ST_IDLE) && !capture;

  // Seeding reuses the update step: class 1 is the candidate against a pair
  // preloaded as (0, 1), which yields best/second for the first two classes.
  always_comb begin
    if (state == ST_SCAN) begin
      cand_score       = snapshot[int'(k)*SCORE_WIDTH +: SCORE_WIDTH];
      cand_idx         = k;
      cur_best_score   = best_score;
      cur_best_idx     = best_idx;
      cur_second_score = second_score;
      cur_second_idx   = second_idx;
    end else begin
      cand_score       = scores_in[SCORE_WIDTH +: SCORE_WIDTH];
      cand_idx         = IDX_WIDTH'(1);
      cur_best_score   = scores_in[0 +: SCORE_WIDTH];
      cur_best_idx     = '0;
      cur_second_score = scores_in[SCORE_WIDTH +: SCORE_WIDTH];
      cur_second_idx   = IDX_WIDTH'(1);
    end
  end

  cnn_top2_update #(
    .SCORE_WIDTH(SCORE_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_update (
    .cand_score      (cand_score),
    .cand_idx        (cand_idx),
    .best_score      (cur_best_score),
    .best_idx        (cur_best_idx),
    .second_score    (cur_second_score),
    .second_idx      (cur_second_idx),
    .new_best_score  (upd_best_score),
    .new_best_idx    (upd_best_idx),
    .new_second_score(upd_second_score),
    .new_second_idx  (upd_second_idx)
  );

  assign margin_next = {upd_best_score[SCORE_WIDTH-1], upd_best_score}
                     - {upd_second_score[SCORE_WIDTH-1], upd_second_score};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      snapshot     <= '0;
      k            <= '0;
      best_score   <= '0;
      best_idx     <= '0;
      second_score <= '0;
      second_idx   <= '0;
      overrun      <= 1'b0;
      class_idx    <= '0;
      class_score  <= '0;
      runner_idx   <= '0;
      margin       <= '0;
      result_valid <= 1'b0;
    end else begin
      overrun <= overrun_next;

      if (finish) begin
        class_idx    <= upd_best_idx;
        class_score  <= upd_best_score;
        runner_idx   <= upd_second_idx;
        margin       <= margin_next;
        result_valid <= 1'b1;
      end else if (handshake) begin
        result_valid <= 1'b0;
      end

      if (capture) begin
        snapshot     <= scores_in;
        best_score   <= upd_best_score;
        best_idx     <= upd_best_idx;
        second_score <= upd_second_score;
        second_idx   <= upd_second_idx;
        k            <= FIRST_SCAN_IDX;
        state        <= TWO_CLASS ? ST_DONE : ST_SCAN;
      end else begin
        case (state)
          ST_SCAN: begin
            if (clken) begin
              best_score   <= upd_best_score;
              best_idx     <= upd_best_idx;
              second_score <= upd_second_score;
              second_idx   <= upd_second_idx;
              k            <= k + IDX_WIDTH'(1);
              if (k == LAST_IDX) state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (result_ready) state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_argmax_top2.sv
// Randomized and directed bench for cnn_argmax_top2 against a plain argmax reference.
module tb_cnn_argmax_top2;
  import cnn_pkg::*;

  localparam int SW = DEF_SCORE_WIDTH;
  localparam int NC = DEF_NUM_CLASSES;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clken = 1'b0;
  logic            scores_valid = 1'b0;
  logic            result_ready = 1'b0;
  logic [SW*NC-1:0] scores_in = '0;
  logic            busy, overrun, result_valid;
  logic [IW-1:0]   class_idx, runner_idx;
  logic [SW-1:0]   class_score;
  logic [SW:0]     margin;

  int compared = 0;
  int mismatched = 0;
  int frame[NC];
  int exp_idx, exp_score, exp_runner, exp_margin;

  cnn_argmax_top2 #(.SCORE_WIDTH(SW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .clken(clken), .scores_in(scores_in),
    .scores_valid(scores_valid), .busy(busy), .overrun(overrun),
    .class_idx(class_idx), .class_score(class_score), .runner_idx(runner_idx),
    .margin(margin), .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: lowest-index maximum wins; runner-up is the lowest-index maximum of the rest.
  task automatic computeModel();
    exp_idx = 0;
    for (int i = 1; i < NC; i++) if (frame[i] > frame[exp_idx]) exp_idx = i;
    exp_runner = -1;
    for (int i = 0; i < NC; i++)
      if (i != exp_idx && (exp_runner < 0 || frame[i] > frame[exp_runner])) exp_runner = i;
    exp_score  = frame[exp_idx];
    exp_margin = frame[exp_idx] - frame[exp_runner];
  endtask

  function automatic int randScore();
    logic signed [15:0] r;
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 6)) - 3;
      1: return ($urandom_range(0, 1) != 0) ? 32767 : -32768;
      default: begin
        r = 16'($urandom);
        return int'(r);
      end
    endcase
  endfunction

  task automatic randomFrame();
    for (int i = 0; i < NC; i++) frame[i] = randScore();
  endtask

  // Presents frame for one cycle (optionally together with result_ready), then scrambles the bus.
  task automatic applyStimulus(input bit with_ready);
    logic [15:0] v;
    for (int i = 0; i < NC; i++) begin
      v = 16'(frame[i]);
      scores_in[i*SW +: SW] = v;
    end
    computeModel();
    scores_valid = 1'b1;
    clken        = 1'b1;
    result_ready = with_ready;
    @(posedge clk); #1;
    scores_valid = 1'b0;
    result_ready = 1'b0;
    for (int i = 0; i < NC; i++) scores_in[i*SW +: SW] = 16'($urandom);
  endtask

  // gate_mode: 0 = clken high, 1 = three low cycles mid-scan, 2 = random gaps.
  task automatic waitResult(input string tag, input int gate_mode);
    int n = 0;
    int lows = 0;
    checkOutput({tag, "_busy"}, 64'(busy), 64'(1));
    while (!result_valid && n < 200) begin
      if (gate_mode == 1)      clken = !(n >= 3 && n < 6);
      else if (gate_mode == 2) clken = ($urandom_range(0, 3) != 0);
      else                     clken = 1'b1;
      if (!clken) lows++;
      @(posedge clk); #1;
      n++;
    end
    clken = 1'b1;
    checkOutput({tag, "_latency"}, 64'(n), 64'(NC - 2 + lows));
  endtask

  task automatic checkResult(input string tag);
    logic [15:0] es;
    logic [16:0] em;
    es = 16'(exp_score);
    em = 17'(exp_margin);
    checkOutput({tag, "_valid"}, 64'(result_valid), 64'(1));
    checkOutput({tag, "_class_idx"}, 64'(class_idx), 64'(exp_idx));
    checkOutput({tag, "_class_score"}, 64'(class_score), 64'(es));
    checkOutput({tag, "_runner_idx"}, 64'(runner_idx), 64'(exp_runner));
    checkOutput({tag, "_margin"}, 64'(margin), 64'(em));
  endtask

  task automatic acceptResult(input string tag);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    checkOutput({tag, "_valid_cleared"}, 64'(result_valid), 64'(0));
    checkOutput({tag, "_idle"}, 64'(busy), 64'(0));
    checkOutput({tag, "_retained"}, 64'(class_idx), 64'(exp_idx));
  endtask

  initial begin
    logic [63:0] held;
    logic [15:0] es;
    logic [16:0] em;

    #12;
    checkOutput("reset_outputs", 64'({busy, overrun, class_idx, class_score, runner_idx, margin, result_valid}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    frame = '{5, -3, 12, 7, 12, 0, -100, 3, 11, 2};
    applyStimulus(1'b0);
    waitResult("basic", 0);
    checkResult("basic");
    checkOutput("basic_literal_idx", 64'(class_idx), 64'(2));
    acceptResult("basic");

    frame = '{-1, -32768, -5, -5, -5, -5, -5, -5, -5, 32767};
    applyStimulus(1'b0);
    waitResult("extreme", 0);
    checkResult("extreme");
    checkOutput("extreme_literal_margin", 64'(margin), 64'(32768));

    es   = 16'(exp_score);
    em   = 17'(exp_margin);
    held = 64'({1'b1, 4'(exp_idx), es, 4'(exp_runner), em});
    for (int c = 0; c < 20; c++) begin
      scores_valid = (c == 10);
      @(posedge clk); #1;
      scores_valid = 1'b0;
      checkOutput("backpressure_hold", 64'({result_valid, class_idx, class_score, runner_idx, margin}), held);
      checkOutput("backpressure_overrun", 64'(overrun), 64'(c == 10));
    end
    acceptResult("extreme");

    randomFrame();
    applyStimulus(1'b0);
    waitResult("b2b_first", 0);
    checkResult("b2b_first");
    randomFrame();
    applyStimulus(1'b1);
    checkOutput("b2b_overrun", 64'(overrun), 64'(0));
    checkOutput("b2b_valid_dropped", 64'(result_valid), 64'(0));
    waitResult("b2b_second", 0);
    checkResult("b2b_second");
    acceptResult("b2b_second");

    frame = '{5, -3, 12, 7, 12, 0, -100, 3, 11, 2};
    applyStimulus(1'b0);
    waitResult("gated", 1);
    checkResult("gated");
    acceptResult("gated");

    randomFrame();
    applyStimulus(1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midscan_reset", 64'({busy, overrun, class_idx, class_score, runner_idx, margin, result_valid}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    randomFrame();
    applyStimulus(1'b0);
    waitResult("after_reset", 0);
    checkResult("after_reset");
    acceptResult("after_reset");

    for (int f = 0; f < 25; f++) begin
      randomFrame();
      applyStimulus(1'b0);
      waitResult("random", 2);
      checkResult("random");
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      acceptResult("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cnn_argmax_top2.md
# cnn_argmax_top2

Post-classifier decision stage placed directly downstream of the CNN top. It captures the fully-connected layer's score vector when that vector is flagged valid. It then scans the scores sequentially, one class per enabled cycle, and tracks the best and second-best class. It presents the winning class, its score, the runner-up class and the decision margin through a valid/ready result handshake.

## Interface
Parameters:
- SCORE_WIDTH, 16, width of one signed score (equals 2×BITWIDTH of the CNN).
- NUM_CLASSES, 10, number of scores; must be ≥ 2.
- IDX_WIDTH, 4, class index width; must be ≥ $clog2(NUM_CLASSES).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clken  in  1  enables capture and scan; the result handshake is not gated.
- scores_in  in  SCORE_WIDTH*NUM_CLASSES  class k at [k*SCORE_WIDTH +: SCORE_WIDTH], signed two's complement.
- scores_valid  in  1  scores_in valid this cycle; typically a one-cycle pulse.
- busy  out  1  high in SCAN or DONE.
- overrun  out  1  one-cycle pulse when scores_valid is dropped.
- class_idx  out  IDX_WIDTH  argmax index.
- class_score  out  SCORE_WIDTH  score at class_idx.
- runner_idx  out  IDX_WIDTH  second-best index.
- margin  out  SCORE_WIDTH+1  class_score − runner-up score, always ≥ 0.
- result_valid  out  1  result fields valid.
- result_ready  in  1  consumer accepts result.

## Operation
- FSM has three states: IDLE, SCAN, DONE. Reset enters IDLE.
- **IDLE**, when scores_valid && clken:
  - snapshot scores_in into an internal register.
  - seed best/second from classes 0 and 1. If s1 > s0, best=1 and second=0; otherwise best=0 and second=1.
  - set k=2.
  - go to SCAN, or to DONE if NUM_CLASSES == 2.
- **SCAN**, each clken cycle:
  - if s_k > best: second←best, best←k.
  - else if s_k > second: second←k.
  - k++. After processing k = NUM_CLASSES−1, go to DONE and set result_valid.
- Comparisons are signed and strict. On ties the lower index keeps priority for both best and second.
- margin is computed as a sign-extended (SCORE_WIDTH+1)-bit subtraction. It is registered on entry to DONE.
- **DONE**: all result fields are held stable while result_valid=1.
  - On result_valid && result_ready: go to IDLE and clear result_valid at that edge.
  - If scores_valid && clken in that same cycle: capture the new frame instead of going idle (back-to-back). No overrun.
- scores_valid in SCAN, or in DONE without the handshake, is ignored and overrun pulses for one cycle.
- clken low freezes the FSM, k and the snapshot. scores_valid with clken low is ignored silently.
- Result fields retain the last result after the handshake. They are only updated on entry to DONE.

## Timing
- Reset values: busy=0, overrun=0, class_idx=0, class_score=0, runner_idx=0, margin=0, result_valid=0. The snapshot and k are also cleared.
- Latency with clken held high, capture at edge E:
  - result_valid rises after edge E+NUM_CLASSES−2 for N ≥ 3 (edge E+8 for N=10).
  - result_valid rises after edge E for N = 2.
- Each low-clken cycle during SCAN adds one cycle of latency.
- Throughput is one frame per NUM_CLASSES−1 cycles with result_ready high.
- Reset asserted mid-SCAN or mid-DONE discards the frame. Outputs return to reset values asynchronously.
- scores_in is needed only in the capture cycle; the upstream stage may change it afterwards.

## Structure
- Shared package cnn_pkg holds:
  - FSM state encodings (IDLE/SCAN/DONE, 2-bit).
  - the default SCORE_WIDTH and NUM_CLASSES constants, shared with the CNN top's FC1_OUTPUT_UNITS and BITWIDTH*2.
- One combinational sub-module, cnn_top2_update: inputs are the candidate score/index and the current best/second; outputs are the updated best/second. It is used by both the seed step and the SCAN step.
- Score muxing uses an indexed part-select on the snapshot. No per-class comparator array.

## Test plan
- **Basic/ties:** scores [5,−3,12,7,12,0,−100,3,11,2], clken=1, result_ready=1 → after 8 edges result_valid=1, class_idx=2, class_score=12, runner_idx=4, margin=0.
- **Signed extremes:** scores [−1,−32768,−5,−5,−5,−5,−5,−5,−5,32767] → class_idx=9, class_score=32767, runner_idx=0, margin=32768, with no wrap.
- **Backpressure/overrun:**
  - hold result_ready=0 for 20 cycles → result fields and result_valid stable throughout.
  - pulse scores_valid at cycle 10 → overrun=1 for exactly one cycle; the result is unchanged.
- **Back-to-back:** result_ready=1 and a new scores_valid in the same cycle as the handshake → no overrun, busy stays 1, second result valid 8 edges later with correct values.
- **clken gating:** drop clken for 3 cycles mid-SCAN → result_valid after 11 edges, values identical to the ungated run.
- **Reset mid-scan:** assert rst_n=0 at scan step 4 → all outputs 0 immediately; the following frame produces the correct result with nominal latency.
